rom_fetch_decode: RTL

Instruction fetch and decode stage directly downstream of the program counter: it consumes the counter's 4-bit ROM address and holds a 16x8 program ROM that can be loaded through a write port. Each new address is fetched, latched into an instruction register, decoded into opcode, operand and one-cycle control strobes, and presented to the execute stage. It also handles halting, illegal opcodes, and addresses that arrive faster than it can fetch them.

---
 rtl/rom_fetch_decode.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/rom_fetch_decode.sv
// Fetch/decode stage: a loadable 16x8 program ROM read at each new PC address,
// decoded into opcode, operand and single-cycle control strobes for execute.
module rom_fetch_decode #(
    parameter int ROM_DEPTH = 16,
    parameter int WORD_W    = 8
) (
    input  logic              CP,
    input  logic              RST,
    input  logic [3:0]        addr,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [3:0]        prog_addr,
    input  logic [WORD_W-1:0] prog_data,
    output logic              instr_valid,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic              ld_acc,
    output logic              alu_add,
    output logic              alu_sub,
    output logic              st_mem,
    output logic              out_en,
    output logic              jump,
    output logic              jump_z,
    output logic              illegal,
    output logic              halted,
    output logic              overrun
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        HALT
    } state_t;

    state_t state, state_next;

    logic [WORD_W-1:0] rom [ROM_DEPTH];
    logic [WORD_W-1:0] rom_data;

    logic [3:0] prev_addr;
    logic [3:0] fetch_addr;
    logic [3:0] pending_addr;
    logic       pending_flag;
    logic       first;
    logic [6:0] strobe_q;

    logic       addr_changed;
    logic       start_fetch;
    logic [3:0] fetch_sel_addr;
    logic       latch_pending;
    logic       clear_pending;
    logic       set_overrun;
    logic       update_prev;
    logic       clear_first;
    logic       do_read;
    logic       do_decode;

    logic [3:0] dec_op;
    logic [6:0] dec_strobes;
    logic       dec_illegal;

    assign addr_changed = (addr != prev_addr);

    always_ff @(posedge CP) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Program mode overrides fetching except once halted, where HALT stays absorbing.
    always_comb begin
        state_next     = state;
        start_fetch    = 1'b0;
        fetch_sel_addr = addr;
        latch_pending  = 1'b0;
        clear_pending  = 1'b0;
        set_overrun    = 1'b0;
        update_prev    = 1'b0;
        clear_first    = 1'b0;
        do_read        = 1'b0;
        do_decode      = 1'b0;

        if (prog_en) begin
            state_next    = (state == HALT || halted) ? HALT : IDLE;
            clear_pending = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (first || addr_changed) begin
                        start_fetch = 1'b1;
                        update_prev = 1'b1;
                        clear_first = 1'b1;
                        state_next  = FETCH;
                    end
                end
                FETCH, DECODE: begin
                    if (state == FETCH) begin
                        do_read    = 1'b1;
                        state_next = DECODE;
                    end else begin
                        do_decode  = 1'b1;
                        state_next = ISSUE;
                    end
                    if (addr_changed) begin
                        latch_pending = 1'b1;
                        update_prev   = 1'b1;
                        set_overrun   = pending_flag;
                    end
                end
                ISSUE: begin
                    if (opcode == 4'hF) begin
                        state_next = HALT;
                    end else if (addr_changed) begin
                        // A change arriving in the issue cycle supersedes any pending address.
                        start_fetch   = 1'b1;
                        update_prev   = 1'b1;
                        clear_pending = 1'b1;
                        set_overrun   = pending_flag;
                        state_next    = FETCH;
                    end else if (pending_flag) begin
                        start_fetch    = 1'b1;
                        fetch_sel_addr = pending_addr;
                        clear_pending  = 1'b1;
                        state_next     = FETCH;
                    end else begin
                        state_next = IDLE;
                    end
                end
                HALT: begin
                    state_next = HALT;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dec_op      = rom_data[WORD_W-1:WORD_W-4];
        dec_strobes = 7'b0000000;
        dec_illegal = 1'b0;
        case (dec_op)
            4'h0, 4'hF: dec_strobes = 7'b0000000;
            4'h1:       dec_strobes = 7'b1000000;
            4'h2:       dec_strobes = 7'b0100000;
            4'h3:       dec_strobes = 7'b0010000;
            4'h4:       dec_strobes = 7'b0001000;
            4'h5:       dec_strobes = 7'b0000100;
            4'h6:       dec_strobes = 7'b0000010;
            4'h7:       dec_strobes = 7'b0000001;
            default:    dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge CP) begin
        if (!RST && prog_en && prog_we) begin
            rom[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            prev_addr    <= 4'h0;
            fetch_addr   <= 4'h0;
            pending_addr <= 4'h0;
            pending_flag <= 1'b0;
            first        <= 1'b1;
            overrun      <= 1'b0;
            rom_data     <= '0;
            instr_valid  <= 1'b0;
            opcode       <= 4'h0;
            operand      <= 4'h0;
            strobe_q     <= 7'b0000000;
            illegal      <= 1'b0;
            halted       <= 1'b0;
        end else begin
            if (update_prev) begin
                prev_addr <= addr;
            end
            if (prog_en) begin
                first <= 1'b1;
            end else if (clear_first) begin
                first <= 1'b0;
            end
            if (start_fetch) begin
                fetch_addr <= fetch_sel_addr;
            end
            if (clear_pending) begin
                pending_flag <= 1'b0;
            end else if (latch_pending) begin
                pending_flag <= 1'b1;
                pending_addr <= addr;
            end
            if (set_overrun) begin
                overrun <= 1'b1;
            end
            if (do_read) begin
                rom_data <= rom[fetch_addr];
            end
            // Opcode/operand form the instruction register and hold between issues.
            instr_valid <= do_decode;
            strobe_q    <= do_decode ? dec_strobes : 7'b0000000;
            illegal     <= do_decode & dec_illegal;
            if (do_decode) begin
                opcode  <= dec_op;
                operand <= rom_data[3:0];
            end
            if (do_decode && dec_op == 4'hF) begin
                halted <= 1'b1;
            end
        end
    end

    assign ld_acc  = strobe_q[6];
    assign alu_add = strobe_q[5];
    assign alu_sub = strobe_q[4];
    assign st_mem  = strobe_q[3];
    assign out_en  = strobe_q[2];
    assign jump    = strobe_q[1];
    assign jump_z  = strobe_q[0];

endmodule
